// File: rtl/fsm_seq_pkg.sv
// Shared definitions for the fsm_seq control sequencer: the 2-bit state
// encoding, which is also exported on the debug state port.
package fsm_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_GAP  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/fsm_seq_cnt.sv
// Loadable up-counter with synchronous clear, count enable and a
// terminal-count flag; used for both the phase and repetition counters.
module fsm_seq_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] d,
   input  logic         en,
   input  logic [W-1:0] term,
   output logic [W-1:0] q,
   output logic         tc
);

   // NOTE: sequential state is assigned with <= so every flop samples the
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst)      q <= '0;
      else if (clr)  q <= '0;
      else if (load) q <= d;
      else if (en)   q <= q + W'(1);
   end

   assign tc = (q == term);

endmodule

// File: rtl/fsm_seq.sv
// Start/done sequencer: len-cycle busy phase repeated reps times, abortable.
// Build option FSM_SEQ_GAP_EN compiles in GAP_CYC idle cycles between reps.
module fsm_seq
   import fsm_seq_pkg::*;
#(
   parameter int LEN_W   = 8,
   parameter int REP_W   = 4,
   parameter int GAP_CYC = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [LEN_W-1:0] len,
   input  logic [REP_W-1:0] reps,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic [LEN_W-1:0] phase_cnt,
   output logic [REP_W-1:0] rep_cnt,
   output logic [1:0]       state
);

`ifdef FSM_SEQ_GAP_EN
   localparam bit               GAP_ON   = (GAP_CYC > 0);
   localparam logic [LEN_W-1:0] GAP_TERM = LEN_W'(GAP_CYC - 1);
`else
   // Gaps are compiled out; GAP_CYC cannot enable them in this build.
   localparam bit GAP_ON = 1'b0 && (GAP_CYC > 0);
`endif

   state_t           state_q, state_d;
   logic [LEN_W-1:0] len_q, phase_term;
   logic [REP_W-1:0] reps_q, rep_term;
   logic             busy_q, done_q, aborted_q, aborted_d, accept;
   logic             phase_clr, phase_en, phase_tc;
   logic             rep_clr, rep_en, rep_tc;

`ifdef FSM_SEQ_GAP_EN
   assign phase_term = (state_q == ST_GAP) ? GAP_TERM : len_q - LEN_W'(1);
`else
   assign phase_term = len_q - LEN_W'(1);
`endif
   assign rep_term = reps_q - REP_W'(1);

   fsm_seq_cnt #(.W(LEN_W)) u_phase (
      .clk(clk), .rst(rst), .clr(phase_clr), .load(1'b0), .d('0),
      .en(phase_en), .term(phase_term), .q(phase_cnt), .tc(phase_tc)
   );

   fsm_seq_cnt #(.W(REP_W)) u_rep (
      .clk(clk), .rst(rst), .clr(rep_clr), .load(1'b0), .d('0),
      .en(rep_en), .term(rep_term), .q(rep_cnt), .tc(rep_tc)
   );

   // NOTE: every signal driven here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      aborted_d = 1'b0;
      phase_clr = 1'b0;
      phase_en  = 1'b0;
      rep_clr   = 1'b0;
      rep_en    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               accept    = 1'b1;
               phase_clr = 1'b1;
               rep_clr   = 1'b1;
               state_d   = (len == '0 || reps == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_d   = ST_IDLE;
               aborted_d = 1'b1;
               phase_clr = 1'b1;
               rep_clr   = 1'b1;
            end else if (phase_tc) begin
               if (rep_tc) begin
                  state_d   = ST_DONE;
                  phase_clr = 1'b1;
                  rep_clr   = 1'b1;
               end else begin
                  rep_en    = 1'b1;
                  phase_clr = 1'b1;
                  state_d   = GAP_ON ? ST_GAP : ST_RUN;
               end
            end else begin
               phase_en = 1'b1;
            end
         end
`ifdef FSM_SEQ_GAP_EN
         ST_GAP: begin
            if (abort) begin
               state_d   = ST_IDLE;
               aborted_d = 1'b1;
               phase_clr = 1'b1;
               rep_clr   = 1'b1;
            end else if (phase_tc) begin
               phase_clr = 1'b1;
               state_d   = ST_RUN;
            end else begin
               phase_en = 1'b1;
            end
         end
`endif
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Flags are registered from the next state so they line up with state.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         len_q     <= '0;
         reps_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            len_q  <= len;
            reps_q <= reps;
         end
         busy_q    <= (state_d == ST_RUN) || (state_d == ST_GAP);
         done_q    <= (state_d == ST_DONE);
         aborted_q <= aborted_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign aborted = aborted_q;
   assign state   = state_q;

endmodule

// File: tb/tb_fsm_seq.sv
// Self-checking bench for fsm_seq: a timeline model built at each accepted
// start, compared every cycle, plus directed literal checks.
module tb_fsm_seq;

   localparam int LEN_W   = 8;
   localparam int REP_W   = 4;
   localparam int GAP_CYC = 2;
`ifdef FSM_SEQ_GAP_EN
   localparam int GAPS = GAP_CYC;
`else
   localparam int GAPS = 0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic [LEN_W-1:0] len = '0;
   logic [REP_W-1:0] reps = '0;
   logic             busy, done, aborted;
   logic [LEN_W-1:0] phase_cnt;
   logic [REP_W-1:0] rep_cnt;
   logic [1:0]       state;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fsm_seq #(.LEN_W(LEN_W), .REP_W(REP_W), .GAP_CYC(GAP_CYC)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .len(len),
      .reps(reps), .busy(busy), .done(done), .aborted(aborted),
      .phase_cnt(phase_cnt), .rep_cnt(rep_cnt), .state(state)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Expected outputs for one cycle; a run is a precomputed list of these.
   typedef struct {
      int st;
      bit busy;
      bit done;
      bit aborted;
      int phase;
      int rep;
   } exp_t;

   function automatic exp_t mk(int st, int phase, int rep, bit dn, bit ab);
      exp_t e;
      e.st = st; e.busy = (st == 1 || st == 2); e.done = dn;
      e.aborted = ab; e.phase = phase; e.rep = rep;
      return e;
   endfunction

   exp_t cur = '{0, 1'b0, 1'b0, 1'b0, 0, 0};
   exp_t tl[$];

   always @(posedge clk) begin
      if (!rst) begin
         tl.delete();
         cur = mk(0, 0, 0, 1'b0, 1'b0);
      end else if (tl.size() != 0) begin
         if (abort && (cur.st == 1 || cur.st == 2)) begin
            tl.delete();
            cur = mk(0, 0, 0, 1'b0, 1'b1);
         end else begin
            cur = tl.pop_front();
         end
      end else if (cur.st == 0 && start) begin
         if (len == 0 || reps == 0) begin
            tl.push_back(mk(3, 0, 0, 1'b1, 1'b0));
         end else begin
            for (int r = 0; r < int'(reps); r++) begin
               for (int p = 0; p < int'(len); p++) tl.push_back(mk(1, p, r, 1'b0, 1'b0));
               if (r < int'(reps) - 1)
                  for (int g = 0; g < GAPS; g++) tl.push_back(mk(2, g, r + 1, 1'b0, 1'b0));
            end
            tl.push_back(mk(3, 0, 0, 1'b1, 1'b0));
         end
         cur = tl.pop_front();
      end else begin
         cur = mk(0, 0, 0, 1'b0, 1'b0);
      end
   end

   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         check("model state", state, cur.st);
         check("model busy", busy, cur.busy);
         check("model done", done, cur.done);
         check("model aborted", aborted, cur.aborted);
         check("model phase_cnt", phase_cnt, cur.phase);
         check("model rep_cnt", rep_cnt, cur.rep);
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 600; i++) begin
         if (state == 2'd0) break;
         step();
      end
      check({tag, " idle reached"}, state, 0);
   endtask

   task automatic kick(input int l, input int r);
      len = LEN_W'(l); reps = REP_W'(r); start = 1'b1;
      step();
      start = 1'b0;
   endtask

   int ph[16], rp[16], st_seq[16];
   int n_run;

   // Called in the first cycle after the accepting edge; returns in the done cycle.
   task automatic measure(input int limit, output int busy_cnt, output int done_cyc, output int max_ph);
      busy_cnt = 0; done_cyc = 0; max_ph = 0; n_run = 0;
      for (int cyc = 1; cyc <= limit; cyc++) begin
         if (cyc <= 16) st_seq[cyc-1] = int'(state);
         if (busy) busy_cnt++;
         if (state == 2'd1 && int'(phase_cnt) > max_ph) max_ph = int'(phase_cnt);
         if (state == 2'd1 && n_run < 16) begin
            ph[n_run] = int'(phase_cnt); rp[n_run] = int'(rep_cnt); n_run++;
         end
         if (done) begin done_cyc = cyc; break; end
         step();
      end
   endtask

   int bc, dc, mp;
   int exp_ph[6] = '{0, 1, 2, 0, 1, 2};
   int exp_rp[6] = '{0, 0, 0, 1, 1, 1};
`ifdef FSM_SEQ_GAP_EN
   int exp_st[11] = '{1, 1, 2, 2, 1, 1, 2, 2, 1, 1, 3};
`else
   int exp_st[7] = '{1, 1, 1, 1, 1, 1, 3};
`endif

   initial begin
      // Reset held with start high.
      rst = 1'b0; start = 1'b1; len = 8'd2; reps = 4'd1;
      step();
      check("reset state", state, 0);
      check("reset busy", busy, 0);
      check("reset phase", phase_cnt, 0);
      step();
      check("reset state 2", state, 0);
      check("reset done", done, 0);
      rst = 1'b1;
      step();
      check("start after reset", state, 1);
      start = 1'b0;
      wait_idle("reset");
      step();

      // Basic run, len/reps changed mid-run.
      kick(3, 2);
      len = 8'd7; reps = 4'd9;
      measure(60, bc, dc, mp);
      check("basic busy cycles", bc, 6 + GAP_CYC * GAPS / GAP_CYC * 1);
      check("basic done cycle", dc, 7 + GAPS);
      for (int i = 0; i < 6; i++) begin
         check("basic phase seq", ph[i], exp_ph[i]);
         check("basic rep seq", rp[i], exp_rp[i]);
      end
      step();
      check("basic done one cycle", done, 0);
      check("basic back to idle", state, 0);

      // Three reps of two cycles, with gaps when compiled in.
      kick(2, 3);
      measure(60, bc, dc, mp);
      check("gap busy cycles", bc, 6 + 2 * GAPS);
      check("gap done cycle", dc, 7 + 2 * GAPS);
      for (int i = 0; i < $size(exp_st); i++) check("gap state seq", st_seq[i], exp_st[i]);
      step();

      // Zero-length run.
      kick(0, 5);
      check("zero state done", state, 3);
      check("zero done pulse", done, 1);
      check("zero busy", busy, 0);
      step();
      check("zero back idle", state, 0);
      check("zero done cleared", done, 0);

      // Abort on the 5th busy cycle.
      kick(4, 2);
      repeat (4) step();
      check("abort5 precondition busy", busy, 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort5 state", state, 0);
      check("abort5 aborted", aborted, 1);
      check("abort5 done", done, 0);
      check("abort5 phase", phase_cnt, 0);
      check("abort5 rep", rep_cnt, 0);
      step();
      check("abort5 pulse one cycle", aborted, 0);

      // Abort on the final RUN cycle wins over completion.
      kick(4, 2);
      repeat (8 + GAPS - 1) step();
      check("abortlast state", state, 1);
      check("abortlast phase", phase_cnt, 3);
      check("abortlast rep", rep_cnt, 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abortlast aborted", aborted, 1);
      check("abortlast done", done, 0);
      check("abortlast state idle", state, 0);
      step();
      check("abortlast no late done", done, 0);

      // start together with abort in IDLE is accepted.
      abort = 1'b1;
      kick(2, 1);
      abort = 1'b0;
      check("start+abort accepted", state, 1);
      check("start+abort no pulse", aborted, 0);
      wait_idle("start+abort");
      step();

      // Reset in the middle of a run.
      kick(5, 3);
      repeat (3) step();
      rst = 1'b0;
      step();
      check("midrst state", state, 0);
      check("midrst busy", busy, 0);
      check("midrst done", done, 0);
      check("midrst aborted", aborted, 0);
      check("midrst phase", phase_cnt, 0);
      check("midrst rep", rep_cnt, 0);
      rst = 1'b1;
      step();
      check("midrst stays idle", state, 0);
      check("midrst no pulse", done | aborted, 0);

      // start held through DONE is not re-accepted until IDLE.
      len = 8'd1; reps = 4'd1; start = 1'b1;
      step();
      check("hold run", state, 1);
      step();
      check("hold done state", state, 3);
      check("hold done pulse", done, 1);
      step();
      check("hold ignored in done", state, 0);
      step();
      check("hold new run", state, 1);
      check("hold new busy", busy, 1);
      start = 1'b0;
      wait_idle("hold");
      step();

      // Maximum length: phase counter stops at len-1 without wrapping.
      kick(255, 1);
      measure(300, bc, dc, mp);
      check("maxlen busy cycles", bc, 255);
      check("maxlen done cycle", dc, 256);
      check("maxlen max phase", mp, 254);
      step();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
